// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package async_fifo_rd_stream_pkg;
    `include "async_fifo_defs.vh"

    typedef enum logic [1:0] {
        ST_EMPTY = EMPTY,
        ST_ONE   = ONE,
        ST_TWO   = TWO
    } state_e;
endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// Valid/ready stream bundle; master drives valid/data.
interface async_fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/async_fifo_defs.vh
// Stream-buffer occupancy codes shared by the read- and write-side
// FIFO adapters.
`ifndef ASYNC_FIFO_DEFS_VH
`define ASYNC_FIFO_DEFS_VH
localparam logic [1:0] EMPTY = 2'd0;
localparam logic [1:0] ONE   = 2'd1;
localparam logic [1:0] TWO   = 2'd2;
`endif

// File: rtl/async_fifo_rd_stream_skid_buf.sv
// Generic 2-entry valid/ready buffer: head drives the output, skid
// holds a second word so the input side never sees out_ready.
module stream_skid_buf
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    state_e        state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign in_ready  = (state_q != ST_TWO);
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d = ST_ONE;
                        head_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_valid && !xfer) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (in_valid) begin
                        head_d  = in_data;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end
endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter: pops the dual-clock FIFO into a skid buffer and
// presents a registered stream, with flush and a delivered-word count.
module async_fifo_rd_stream
    import async_fifo_rd_stream_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic [DSIZE-1:0]        fifo_rdata,
    input  logic                    fifo_rempty,
    output logic                    fifo_rinc,
    async_fifo_rd_stream_if.master  m,
    input  logic                    flush,
    output logic [CNT_W-1:0]        rd_count
);
    logic             buf_ready;
    logic             push;
    logic             valid;
    logic [DSIZE-1:0] data;
    logic             xfer;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Flush drains the FIFO regardless of buffer occupancy.
    assign fifo_rinc = rrst_n & ~fifo_rempty & (flush | buf_ready);
    assign push      = fifo_rinc & ~flush;
    assign xfer      = valid & m.ready;

    stream_skid_buf #(
        .DW(DSIZE)
    ) u_buf (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .flush    (flush),
        .in_valid (push),
        .in_data  (fifo_rdata),
        .in_ready (buf_ready),
        .out_valid(valid),
        .out_ready(m.ready),
        .out_data (data)
    );

    assign m.valid  = valid;
    assign m.data   = data;
    assign rd_count = cnt_q;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(xfer);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_no_underflow: assert property (
        @(posedge rclk) fifo_rinc |-> !fifo_rempty
    );
endmodule
